// File: rtl/fp32_addsub_cmp.sv
// rtl/fp32_addsub_cmp.sv - registered binary32 add/subtract with magnitude comparator
// Truncating adder (no guard/round/sticky), denormals flushed to zero, fixed 1-cycle latency.

module fp32_addsub_cmp (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    input  logic        add_sub_signal,
    output logic        out_valid,
    output logic [31:0] result,
    output logic        Exception,
    output logic        greater
);

    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        n = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (v[i]) n = 5'(23 - i);
        end
        return n;
    endfunction

    logic        out_valid_q;
    logic [31:0] result_q;
    logic        exception_q;
    logic        greater_q;

    logic [31:0] result_d;
    logic        exception_d;
    logic        greater_d;

    logic [7:0]  a_exp, b_exp;
    logic [30:0] a_mag, b_mag;
    logic        b_sign_eff;
    logic        swap;
    logic        l_sign, s_sign;
    logic [30:0] l_mag, s_mag;
    logic [7:0]  l_exp, s_exp;
    logic [23:0] l_sig, s_sig;
    logic [7:0]  shift;
    logic [23:0] s_aligned;
    logic [24:0] sum;
    logic [23:0] diff;
    logic [4:0]  lz;
    logic [23:0] norm;
    logic [8:0]  exp_inc;
    logic        a_nan, b_nan;
    logic        both_zero;
    logic        cmp_raw;

    always_comb begin
        a_exp      = a_operand[30:23];
        b_exp      = b_operand[30:23];
        // Denormals collapse to a zero magnitude before any ordering.
        a_mag      = (a_exp == 8'd0) ? 31'd0 : a_operand[30:0];
        b_mag      = (b_exp == 8'd0) ? 31'd0 : b_operand[30:0];
        b_sign_eff = b_operand[31] ^ add_sub_signal;

        swap   = (b_mag > a_mag);
        l_sign = swap ? b_sign_eff : a_operand[31];
        s_sign = swap ? a_operand[31] : b_sign_eff;
        l_mag  = swap ? b_mag : a_mag;
        s_mag  = swap ? a_mag : b_mag;
        l_exp  = l_mag[30:23];
        s_exp  = s_mag[30:23];
        l_sig  = (l_exp == 8'd0) ? 24'd0 : {1'b1, l_mag[22:0]};
        s_sig  = (s_exp == 8'd0) ? 24'd0 : {1'b1, s_mag[22:0]};

        shift     = l_exp - s_exp;
        s_aligned = (shift >= 8'd24) ? 24'd0 : (s_sig >> shift);
        sum       = {1'b0, l_sig} + {1'b0, s_aligned};
        diff      = l_sig - s_aligned;
        lz        = lzc24(diff);
        norm      = diff << lz;
        exp_inc   = {1'b0, l_exp} + 9'd1;

        result_d    = 32'd0;
        exception_d = 1'b0;

        if ((a_exp == 8'hFF) || (b_exp == 8'hFF)) begin
            exception_d = 1'b1;
        end else if (l_sign == s_sign) begin
            if (sum == 25'd0) begin
                result_d = 32'd0;
            end else if (sum[24]) begin
                if (exp_inc >= 9'd255) begin
                    result_d    = {l_sign, 8'hFF, 23'd0};
                    exception_d = 1'b1;
                end else begin
                    result_d = {l_sign, exp_inc[7:0], sum[23:1]};
                end
            end else begin
                result_d = {l_sign, l_exp, sum[22:0]};
            end
        end else begin
            // Cancellation below the smallest normal exponent flushes to +0.
            if ((diff == 24'd0) || ({3'd0, lz} >= l_exp)) begin
                result_d = 32'd0;
            end else begin
                result_d = {l_sign, l_exp - {3'd0, lz}, norm[22:0]};
            end
        end

        a_nan     = (a_exp == 8'hFF) && (a_operand[22:0] != 23'd0);
        b_nan     = (b_exp == 8'hFF) && (b_operand[22:0] != 23'd0);
        both_zero = (a_mag == 31'd0) && (b_mag == 31'd0);
        case ({a_operand[31], b_operand[31]})
            2'b00:   cmp_raw = (a_mag > b_mag);
            2'b11:   cmp_raw = (a_mag < b_mag);
            2'b01:   cmp_raw = !both_zero;
            default: cmp_raw = 1'b0;
        endcase
        greater_d = cmp_raw && !(a_nan || b_nan);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            result_q    <= 32'd0;
            exception_q <= 1'b0;
            greater_q   <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                result_q    <= result_d;
                exception_q <= exception_d;
                greater_q   <= greater_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign Exception = exception_q;
    assign greater   = greater_q;

endmodule

// File: tb/tb_fp32_addsub_cmp.sv
// tb/tb_fp32_addsub_cmp.sv - randomized self-checking bench for fp32_addsub_cmp

module tb_fp32_addsub_cmp;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] a_operand = 32'd0;
    logic [31:0] b_operand = 32'd0;
    logic        add_sub_signal = 1'b0;
    logic        out_valid;
    logic [31:0] result;
    logic        Exception;
    logic        greater;

    int tests = 0;
    int fails = 0;

    logic        m_valid;
    logic [33:0] m_out;

    fp32_addsub_cmp dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .a_operand     (a_operand),
        .b_operand     (b_operand),
        .add_sub_signal(add_sub_signal),
        .out_valid     (out_valid),
        .result        (result),
        .Exception     (Exception),
        .greater       (greater)
    );

    always #5 clk = ~clk;

    // Value-level reference: {greater, Exception, result}
    function automatic logic [33:0] ref_model(input logic [31:0] a, input logic [31:0] b, input logic op);
        longint ka, kb, sa_k, sb_k, ml, ms, m;
        int ea, eb, el, es, e, sh;
        logic sl, ss, exc, g, nan;
        logic [31:0] r;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        ka = (ea == 0) ? 64'sd0 : longint'(a[30:0]);
        kb = (eb == 0) ? 64'sd0 : longint'(b[30:0]);
        nan = (ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0);
        sa_k = a[31] ? -ka : ka;
        sb_k = b[31] ? -kb : kb;
        g = !nan && (sa_k > sb_k);
        exc = 1'b0;
        r = 32'd0;
        if (ea == 255 || eb == 255) begin
            exc = 1'b1;
        end else begin
            if (kb > ka) begin
                el = eb; es = ea; sl = b[31] ^ op; ss = a[31];
                ml = (eb == 0) ? 64'sd0 : (64'sd1 << 23) + longint'(b[22:0]);
                ms = (ea == 0) ? 64'sd0 : (64'sd1 << 23) + longint'(a[22:0]);
            end else begin
                el = ea; es = eb; sl = a[31]; ss = b[31] ^ op;
                ml = (ea == 0) ? 64'sd0 : (64'sd1 << 23) + longint'(a[22:0]);
                ms = (eb == 0) ? 64'sd0 : (64'sd1 << 23) + longint'(b[22:0]);
            end
            sh = el - es;
            ms = (sh >= 24) ? 64'sd0 : (ms >>> sh);
            m = (sl == ss) ? ml + ms : ml - ms;
            e = el;
            if (m != 0) begin
                while (m >= (64'sd1 << 24)) begin m = m >>> 1; e++; end
                while (m < (64'sd1 << 23)) begin m = m <<< 1; e--; end
                if (e >= 255) begin
                    r = {sl, 8'hFF, 23'd0};
                    exc = 1'b1;
                end else if (e > 0) begin
                    r = {sl, 8'(e), 23'(m)};
                end
            end
        end
        return {g, exc, r};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 9))
            0: v[30:0] = 31'd0;
            1: begin v[30:23] = 8'hFF; if ($urandom_range(0, 1) == 0) v[22:0] = 23'd0; end
            2: v[30:23] = 8'd0;
            3: v[30:23] = 8'hFE;
            4: v[30:23] = 8'($urandom_range(1, 3));
            default: v[30:23] = 8'($urandom_range(120, 135));
        endcase
        return v;
    endfunction

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic op);
        @(negedge clk);
        in_valid = v;
        a_operand = a;
        b_operand = b;
        add_sub_signal = op;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_out   <= 34'd0;
        end else begin
            m_valid <= in_valid;
            if (in_valid) m_out <= ref_model(a_operand, b_operand, add_sub_signal);
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("cycle {valid,greater,exc,result}",
                {2'b00, out_valid, greater, Exception, result},
                {2'b00, m_valid, m_out});
        end
    end

    logic [31:0] da [12] = '{32'h3FC00000, 32'h42700000, 32'h42200000, 32'h3F800000,
                             32'hBF800000, 32'hBF800000, 32'h80000000, 32'h7F800000,
                             32'h7F7FFFFF, 32'h7FC00000, 32'h4B800000, 32'h3F800000};
    logic [31:0] db [12] = '{32'h40100000, 32'h42200000, 32'h42200000, 32'h3F800000,
                             32'h3F800000, 32'hC0000000, 32'h00000000, 32'h3F800000,
                             32'h7F7FFFFF, 32'h3F800000, 32'h3F800000, 32'h00400000};
    logic        dop [12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [33:0] dexp [12] = '{{1'b0, 1'b0, 32'h40700000}, {1'b1, 1'b0, 32'h41A00000},
                               {1'b0, 1'b0, 32'h00000000}, {1'b0, 1'b0, 32'h40000000},
                               {1'b0, 1'b0, 32'h00000000}, {1'b1, 1'b0, 32'hC0400000},
                               {1'b0, 1'b0, 32'h00000000}, {1'b1, 1'b1, 32'h00000000},
                               {1'b0, 1'b1, 32'h7F800000}, {1'b0, 1'b1, 32'h00000000},
                               {1'b1, 1'b0, 32'h4B800000}, {1'b1, 1'b0, 32'h3F800000}};

    initial begin
        logic [31:0] ra, rb;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("model_pin_%0d", i), {2'b00, ref_model(da[i], db[i], dop[i])}, {2'b00, dexp[i]});
        end

        #12;
        chk("reset_state", {2'b00, out_valid, greater, Exception, result}, 36'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) drive(1'b1, da[i], db[i], dop[i]);
        for (int i = 0; i < 12; i++) drive(1'(i % 2), da[i], db[i], dop[i]);
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        drive(1'b0, 32'd0, 32'd0, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            ra = rand_fp();
            case ($urandom_range(0, 5))
                0: rb = ra;
                1: rb = {~ra[31], ra[30:0]};
                2: rb = ra ^ {9'd0, 23'($urandom_range(0, 255))};
                default: rb = rand_fp();
            endcase
            drive(($urandom_range(0, 7) != 0), ra, rb, 1'($urandom_range(0, 1)));
        end

        drive(1'b1, 32'h3FC00000, 32'h40100000, 1'b0);
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_mid_cycle", {2'b00, out_valid, greater, Exception, result}, 36'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 32'h42700000, 32'h42200000, 1'b1);
        drive(1'b1, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0);
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        drive(1'b0, 32'd0, 32'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
